// File: rtl/svm_seq_mac_engine_pkg.sv
// Shared types, default widths and helpers for the sequential SVM MAC engine.
package svm_seq_mac_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N_FEATURES_DEF   = 34;
  localparam int FEAT_WIDTH_DEF   = 4;
  localparam int WEIGHT_WIDTH_DEF = 8;
  localparam int BIAS_WIDTH_DEF   = 12;
  localparam int ACC_WIDTH_DEF    = 20;
  localparam int N_CLASSES_DEF    = 6;

  // Signed weight times zero-extended unsigned feature.
  localparam int PROD_WIDTH = WEIGHT_WIDTH_DEF + FEAT_WIDTH_DEF + 1;

  // Ceiling log2, never below 1 so a single-entry counter still has a bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/svm_seq_mac_engine_mac_unit.sv
// Combinational multiply-accumulate step: selects feature/weight idx and adds
// the full-precision signed product onto the running accumulator.
module svm_seq_mac_engine_mac_unit #(
  parameter int N_FEATURES   = 34,
  parameter int FEAT_WIDTH   = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 20,
  parameter int IDX_WIDTH    = 6
) (
  input  logic [FEAT_WIDTH*N_FEATURES-1:0]   feat_i,
  input  logic [WEIGHT_WIDTH*N_FEATURES-1:0] weight_i,
  input  logic [IDX_WIDTH-1:0]               idx_i,
  input  logic signed [ACC_WIDTH-1:0]        acc_i,
  output logic signed [ACC_WIDTH-1:0]        acc_o
);

  localparam int PROD_W = WEIGHT_WIDTH + FEAT_WIDTH + 1;

  logic signed [WEIGHT_WIDTH-1:0] w_sel;
  logic [FEAT_WIDTH-1:0]          x_sel;
  logic signed [PROD_W-1:0]       prod;
  int                             sel;

  // Slice select, signed product, sign-extended accumulate.
  always_comb begin
    sel   = int'(idx_i);
    w_sel = weight_i[sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    x_sel = feat_i[sel*FEAT_WIDTH +: FEAT_WIDTH];
    prod  = PROD_W'(w_sel) * PROD_W'($signed({1'b0, x_sel}));
    acc_o = acc_i + ACC_WIDTH'(prod);
  end

endmodule

// File: rtl/svm_seq_mac_engine.sv
// Sequential binary-SVM evaluator: runs N_CLASSES-1 pairwise decisions per
// sample, one feature per cycle, against weights/bias supplied by the picker.
//
// state | meaning
// IDLE  | waiting for in_valid_i; features latched on acceptance
// LOAD  | accumulator seeded with bias, feature index cleared
// MAC   | one weight*feature product accumulated per cycle
// DONE  | svmready_o/w_class_o presented; next decision or back to IDLE
module svm_seq_mac_engine
  import svm_seq_mac_engine_pkg::*;
#(
  parameter int N_FEATURES   = N_FEATURES_DEF,
  parameter int FEAT_WIDTH   = FEAT_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int BIAS_WIDTH   = BIAS_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int N_CLASSES    = N_CLASSES_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid_i,
  input  logic [FEAT_WIDTH*N_FEATURES-1:0]   features_i,
  input  logic [WEIGHT_WIDTH*N_FEATURES-1:0] weight_i,
  input  logic [BIAS_WIDTH-1:0]              bia_i,
  output logic                               busy_o,
  output logic                               w_class_o,
  output logic                               svmready_o,
  output logic                               sample_done_o
);

  localparam int IDX_WIDTH = clog2(N_FEATURES);
  localparam int DEC_WIDTH = clog2(N_CLASSES);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(N_FEATURES - 1);
  localparam logic [DEC_WIDTH-1:0] DEC_LAST = DEC_WIDTH'(N_CLASSES - 2);

  state_t                           state_q;
  logic [FEAT_WIDTH*N_FEATURES-1:0] feat_q;
  logic signed [ACC_WIDTH-1:0]      acc_q;
  logic signed [ACC_WIDTH-1:0]      acc_d;
  logic [IDX_WIDTH-1:0]             idx_q;
  logic [DEC_WIDTH-1:0]             dec_cnt_q;
  logic                             busy_q;
  logic                             w_class_q;
  logic                             svmready_q;
  logic                             sample_done_q;
  logic signed [ACC_WIDTH-1:0]      bias_ext;

  assign bias_ext = ACC_WIDTH'($signed(bia_i));

  svm_seq_mac_engine_mac_unit #(
    .N_FEATURES   (N_FEATURES),
    .FEAT_WIDTH   (FEAT_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH),
    .IDX_WIDTH    (IDX_WIDTH)
  ) u_mac (
    .feat_i   (feat_q),
    .weight_i (weight_i),
    .idx_i    (idx_q),
    .acc_i    (acc_q),
    .acc_o    (acc_d)
  );

  // Sequencer: pulses are set on entry to DONE so they are high for exactly
  // the DONE cycle, and the picker sees them before the next LOAD reads bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      feat_q        <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      dec_cnt_q     <= '0;
      busy_q        <= 1'b0;
      w_class_q     <= 1'b0;
      svmready_q    <= 1'b0;
      sample_done_q <= 1'b0;
    end else begin
      svmready_q    <= 1'b0;
      sample_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            feat_q    <= features_i;
            dec_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          acc_q   <= bias_ext;
          idx_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDX_WIDTH'(1);
          if (idx_q == IDX_LAST) begin
            state_q       <= DONE;
            svmready_q    <= 1'b1;
            w_class_q     <= ~acc_d[ACC_WIDTH-1];
            sample_done_q <= (dec_cnt_q == DEC_LAST);
          end
        end
        DONE: begin
          dec_cnt_q <= dec_cnt_q + DEC_WIDTH'(1);
          if (dec_cnt_q == DEC_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign w_class_o     = w_class_q;
  assign svmready_o    = svmready_q;
  assign sample_done_o = sample_done_q;

endmodule

// File: tb/tb_svm_seq_mac_engine.sv
// Bench for svm_seq_mac_engine. A small picker stand-in drives weight/bias per
// decision from the current vector record and advances on each svmready.
module tb_svm_seq_mac_engine;

  localparam int NF     = 34;
  localparam int FW     = 4;
  localparam int WW     = 8;
  localparam int BW     = 12;
  localparam int PERIOD = NF + 2;
  localparam int NDEC   = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid_i;
  logic [FW*NF-1:0] features_i;
  logic [WW*NF-1:0] weight_i;
  logic [BW-1:0]   bia_i;
  logic            busy_o;
  logic            w_class_o;
  logic            svmready_o;
  logic            sample_done_o;

  typedef struct packed {
    logic            ramp;
    logic [3:0]      x;
    logic [4:0][7:0] w;
    logic [4:0][11:0] b;
    logic [4:0]      exp_wc;
  } vec_t;

  vec_t vecs [6];
  vec_t cur;
  int   dec_k;
  int   n_pass;
  int   n_chk;

  svm_seq_mac_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid_i),
    .features_i    (features_i),
    .weight_i      (weight_i),
    .bia_i         (bia_i),
    .busy_o        (busy_o),
    .w_class_o     (w_class_o),
    .svmready_o    (svmready_o),
    .sample_done_o (sample_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Picker stand-in: weights/bias for the current decision.
  always_comb begin
    int dk;
    dk = (dec_k > 4) ? 4 : dec_k;
    weight_i = '0;
    bia_i = cur.b[dk];
    for (int i = 0; i < NF; i++)
      weight_i[i*WW +: WW] = cur.ramp ? WW'(i - 17) : cur.w[dk];
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ramp, input logic [3:0] x,
                              input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3,
                              input logic [7:0] w4,
                              input logic [11:0] b0, input logic [11:0] b1,
                              input logic [11:0] b2, input logic [11:0] b3,
                              input logic [11:0] b4, input logic [4:0] e);
    vec_t v;
    v.ramp = ramp;
    v.x = x;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.exp_wc = e;
    return v;
  endfunction

  function automatic logic [FW*NF-1:0] pack_feat(input vec_t v);
    logic [FW*NF-1:0] f;
    for (int i = 0; i < NF; i++)
      f[i*FW +: FW] = v.ramp ? FW'(i % 16) : v.x;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a sample and return one cycle after acceptance (state LOAD).
  task automatic start_sample(input int v);
    logic [159:0] junk;
    cur   = vecs[v];
    dec_k = 0;
    @(negedge clk);
    features_i = pack_feat(cur);
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
    features_i = junk[FW*NF-1:0];
  endtask

  task automatic run_vec(input int v, input bit inject);
    int cyc;
    int pulses;
    int stray;
    start_sample(v);
    check($sformatf("v%0d_busy_after_accept", v), int'(busy_o), 1);
    cyc = 1;
    pulses = 0;
    stray = 0;
    while (pulses < NDEC && cyc <= NDEC*PERIOD + 4) begin
      in_valid_i = (inject && cyc == 50);
      if (svmready_o) begin
        check($sformatf("v%0d_d%0d_svmready_cycle", v, pulses), cyc, (pulses+1)*PERIOD);
        check($sformatf("v%0d_d%0d_w_class", v, pulses), int'(w_class_o), int'(cur.exp_wc[pulses]));
        check($sformatf("v%0d_d%0d_sample_done", v, pulses), int'(sample_done_o),
              (pulses == NDEC-1) ? 1 : 0);
        pulses++;
        dec_k++;
        if (inject && pulses == NDEC) in_valid_i = 1'b1;
      end else if (sample_done_o) begin
        stray++;
      end
      if (pulses < NDEC) begin
        step();
        cyc++;
      end
    end
    check($sformatf("v%0d_pulse_count", v), pulses, NDEC);
    check($sformatf("v%0d_stray_sample_done", v), stray, 0);
    step();
    in_valid_i = 1'b0;
    check($sformatf("v%0d_busy_after_done", v), int'(busy_o), 0);
    check($sformatf("v%0d_svmready_after_done", v), int'(svmready_o), 0);
    if (inject) begin
      stray = 0;
      for (int i = 0; i < 5; i++) begin
        if (busy_o || svmready_o) stray++;
        step();
      end
      check("drop_in_valid_at_sample_done", stray, 0);
    end
  endtask

  initial begin
    int bad;
    int cyc;
    int pulses;
    n_pass = 0;
    n_chk  = 0;
    dec_k  = 0;
    rst_n  = 1'b0;
    in_valid_i = 1'b0;
    features_i = '0;

    //                ramp x     w0       w1       w2      w3       w4
    //                b0        b1        b2        b3        b4        exp(d4..d0)
    vecs[0] = mk(1'b0, 4'd1,  8'sd1,   8'sd1,   8'sd1,  8'sd1,   8'sd1,
                 12'sd0,   12'sd0,   12'sd0,   12'sd0,   12'sd0,   5'b11111);
    vecs[1] = mk(1'b0, 4'd15, -8'sd1,  -8'sd1,  -8'sd1, -8'sd1,  -8'sd1,
                 12'sd510, 12'sd509, 12'sd510, 12'sd509, 12'sd510, 5'b10101);
    // w=-128, b=-2048: acc = -2048 - 34*1920 = -67328
    vecs[2] = mk(1'b0, 4'd15, 8'h80,   8'h80,   8'h80,  8'h80,   8'h80,
                 12'h800,  12'h800,  12'h800,  12'h800,  12'h800,  5'b00000);
    vecs[3] = mk(1'b0, 4'd0,  8'h80,   8'h80,   8'h80,  8'h80,   8'h80,
                 12'sd0,   -12'sd1,  12'sd1,   12'h800,  12'sd2047, 5'b10101);
    // acc: 62722, -67328, -1538, -2558, -2048
    vecs[4] = mk(1'b0, 4'd15, 8'sd127, 8'h80,   8'sd1,  -8'sd1,  8'sd0,
                 12'h800,  12'h800,  12'h800,  12'h800,  12'h800,  5'b00001);
    // x[i]=i%16, w[i]=i-17: dot product 336; acc = 0,-1,0,336,-664
    vecs[5] = mk(1'b1, 4'd0,  8'sd0,   8'sd0,   8'sd0,  8'sd0,   8'sd0,
                 -12'sd336, -12'sd337, -12'sd336, 12'sd0, -12'sd1000, 5'b01101);
    cur = vecs[0];

    // Reset state
    repeat (3) step();
    check("rst_busy", int'(busy_o), 0);
    check("rst_svmready", int'(svmready_o), 0);
    check("rst_w_class", int'(w_class_o), 0);
    check("rst_sample_done", int'(sample_done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no in_valid
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy_o || svmready_o || sample_done_o) bad++;
    end
    check("idle_100_quiet", bad, 0);

    // Table-driven samples; vector 1 also pulses in_valid while busy
    // and coincident with sample_done.
    for (int v = 0; v < 6; v++) run_vec(v, v == 1);

    // Reset mid-MAC: decision 3, idx 17 is cycle 3*36 + 2 + 17 = 127.
    start_sample(0);
    cyc = 1;
    pulses = 0;
    while (cyc < 127) begin
      step();
      cyc++;
      if (svmready_o) begin
        pulses++;
        dec_k++;
      end
    end
    check("midrst_pulses_before", pulses, 3);
    check("midrst_busy_before", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_svmready", int'(svmready_o), 0);
    check("midrst_w_class", int'(w_class_o), 0);
    check("midrst_sample_done", int'(sample_done_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy_o || svmready_o) bad++;
    end
    check("midrst_quiet_after", bad, 0);
    run_vec(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
